// File: rtl/key_hex_counter_n.sv
// key_hex_counter_n: debounced active-low push keys driving per-channel
// 4-bit up/down counters, each shown on an active-low 7-segment hex digit.
module key_hex_counter_n #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   key,
  input  logic [1:0]            SW,
  output logic [7*CHANNELS-1:0] hex,
  output logic [CHANNELS-1:0]   press_pulse
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES + 1 > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

  // Active-low glyph table, segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] f_glyph(input logic [3:0] v);
    logic [6:0] seg;
    seg = 7'b1000000;
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1000000;
    endcase
    return seg;
  endfunction

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [DW-1:0] r_dcnt;
    logic [3:0]    r_val;
    logic          r_pulse;
    logic          w_differ;
    logic          w_accept;
    logic          w_press;

    // Debounce decision: accept a level change after DEBOUNCE_CYCLES differing cycles
    always_comb begin
      w_differ = 1'b0;
      w_accept = 1'b0;
      w_press  = 1'b0;
      w_differ = (r_sync2 != r_stable);
      w_accept = w_differ && (r_dcnt == DLAST);
      w_press  = w_accept && r_stable;
    end

    // Two-flop synchroniser for the asynchronous key
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
      end else begin
        r_sync1 <= key[c];
        r_sync2 <= r_sync1;
      end
    end

    // Stable level and debounce counter; any bounce back restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stable <= 1'b1;
        r_dcnt   <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_dcnt   <= '0;
      end else if (w_differ) begin
        r_dcnt   <= r_dcnt + DW'(1);
      end else begin
        r_dcnt   <= '0;
      end
    end

    // One-cycle strobe on each accepted press (released -> pressed)
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= w_press;
      end
    end

    // Counter: clear wins over a press; otherwise step in SW[0] direction
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_val <= 4'd0;
      end else if (SW[1]) begin
        r_val <= 4'd0;
      end else if (w_press) begin
        r_val <= SW[0] ? (r_val - 4'd1) : (r_val + 4'd1);
      end
    end

    assign press_pulse[c]  = r_pulse;
    assign hex[7*c +: 7]   = f_glyph(r_val);
  end

endmodule

// File: tb/tb_key_hex_counter_n.sv
// Testbench for key_hex_counter_n: directed scenarios plus random key
// activity, checked against a cycle-level behavioural model.
module tb_key_hex_counter_n;

  localparam int unsigned CH = 4;
  localparam int unsigned D  = 4;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] GF = 7'b0001110;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   key;
  logic [1:0]      SW;
  logic [7*CH-1:0] hex;
  logic [CH-1:0]   press_pulse;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: synchronised key history, accepted level, run length of disagreement
  logic [CH-1:0] m_ks1, m_ks2, m_st, m_pulse;
  int            m_run [CH];
  logic [3:0]    m_val [CH];

  key_hex_counter_n #(.CHANNELS(CH), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .SW(SW), .hex(hex), .press_pulse(press_pulse));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ks1 = '1; m_ks2 = '1; m_st = '1; m_pulse = '0;
    for (int c = 0; c < int'(CH); c++) begin
      m_run[c] = 0;
      m_val[c] = 4'd0;
    end
  endtask

  // A level is accepted once the synchronised key has disagreed with it on D consecutive edges
  task automatic model_edge();
    logic [CH-1:0] np;
    np = '0;
    for (int c = 0; c < int'(CH); c++) begin
      if (m_ks2[c] != m_st[c]) begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] == int'(D)) begin
          m_st[c]  = m_ks2[c];
          m_run[c] = 0;
          if (!m_st[c]) np[c] = 1'b1;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    for (int c = 0; c < int'(CH); c++) begin
      if (SW[1])      m_val[c] = 4'd0;
      else if (np[c]) m_val[c] = SW[0] ? 4'((m_val[c] + 15) % 16) : 4'((m_val[c] + 1) % 16);
    end
    m_pulse = np;
    m_ks2   = m_ks1;
    m_ks1   = key;
  endtask

  function automatic logic [7*CH-1:0] exp_hex();
    logic [7*CH-1:0] r;
    for (int c = 0; c < int'(CH); c++) r[7*c +: 7] = GLYPH[m_val[c]];
    return r;
  endfunction

  // Drive inputs at the falling edge, advance through one rising edge
  task automatic step(input logic [CH-1:0] k, input logic [1:0] s);
    key = k;
    SW  = s;
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key = '1; SW = 2'b00;
    model_reset();
    #2;
    n_vec++;
    if ({hex, press_pulse} !== {{CH{G0}}, 4'b0000}) begin
      n_err++;
      $display("FAIL reset_values: hex=%h pulse=%b want hex=%h pulse=0000", hex, press_pulse, {CH{G0}});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step('1, 2'b00);
      n_vec++;
      if ({hex, press_pulse} !== {exp_hex(), m_pulse}) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: hex=%h pulse=%b want hex=%h pulse=%b", i, hex, press_pulse, exp_hex(), m_pulse);
      end
    end
    n_vec++;
    if (hex !== {CH{G0}}) begin
      n_err++;
      $display("FAIL reset_idle_end: hex=%h want %h", hex, {CH{G0}});
    end
  endtask

  task automatic test_clean_press();
    int pe, np;
    pe = -1; np = 0;
    for (int i = 0; i < 60; i++) begin
      step(4'b1110, 2'b00);
      n_vec++;
      if ({hex, press_pulse} !== {exp_hex(), m_pulse}) begin
        n_err++;
        $display("FAIL clean_press[%0d]: hex=%h pulse=%b want hex=%h pulse=%b", i, hex, press_pulse, exp_hex(), m_pulse);
      end
      if (press_pulse[0]) begin
        np++;
        if (pe < 0) pe = i;
      end
    end
    n_vec++;
    if (pe != int'(D) + 1 || np != 1) begin
      n_err++;
      $display("FAIL clean_press_latency: first pulse edge %0d count %0d want edge %0d count 1", pe, np, D + 1);
    end
    n_vec++;
    if (hex[6:0] !== G1) begin
      n_err++;
      $display("FAIL clean_press_digit0: %b want %b", hex[6:0], G1);
    end
    for (int i = 0; i < 10; i++) step('1, 2'b00);
  endtask

  task automatic test_bounce();
    int np;
    np = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        step((i < 3) ? 4'b1101 : 4'b1111, 2'b00);
        n_vec++;
        if ({hex, press_pulse} !== {exp_hex(), m_pulse}) begin
          n_err++;
          $display("FAIL bounce[%0d.%0d]: hex=%h pulse=%b want hex=%h pulse=%b", r, i, hex, press_pulse, exp_hex(), m_pulse);
        end
        if (press_pulse[1]) np++;
      end
    end
    n_vec++;
    if (np != 0 || hex[13:7] !== G0) begin
      n_err++;
      $display("FAIL bounce_reject: pulses %0d digit1 %b want 0 and %b", np, hex[13:7], G0);
    end
    for (int i = 0; i < 12; i++) begin
      step(4'b1101, 2'b00);
      n_vec++;
      if ({hex, press_pulse} !== {exp_hex(), m_pulse}) begin
        n_err++;
        $display("FAIL bounce_hold[%0d]: hex=%h pulse=%b want hex=%h pulse=%b", i, hex, press_pulse, exp_hex(), m_pulse);
      end
      if (press_pulse[1]) np++;
    end
    n_vec++;
    if (np != 1 || hex[13:7] !== G1) begin
      n_err++;
      $display("FAIL bounce_accept: pulses %0d digit1 %b want 1 and %b", np, hex[13:7], G1);
    end
    for (int i = 0; i < 10; i++) step('1, 2'b00);
  endtask

  task automatic test_wrap_dir();
    for (int p = 0; p < 17; p++) begin
      for (int i = 0; i < 16; i++) begin
        step((i < 8) ? 4'b1011 : 4'b1111, (p == 16) ? 2'b01 : 2'b00);
        n_vec++;
        if ({hex, press_pulse} !== {exp_hex(), m_pulse}) begin
          n_err++;
          $display("FAIL wrap[%0d.%0d]: hex=%h pulse=%b want hex=%h pulse=%b", p, i, hex, press_pulse, exp_hex(), m_pulse);
        end
      end
      if (p == 15) begin
        n_vec++;
        if (hex[20:14] !== G0) begin
          n_err++;
          $display("FAIL wrap_up_digit2: %b want %b", hex[20:14], G0);
        end
      end
    end
    n_vec++;
    if (hex[20:14] !== GF) begin
      n_err++;
      $display("FAIL wrap_down_digit2: %b want %b", hex[20:14], GF);
    end
  endtask

  task automatic test_clear_concurrency();
    logic [CH-1:0] seen;
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 16; i++) step((i < 8) ? 4'b0000 : 4'b1111, 2'b00);
    n_vec++;
    if (hex !== {CH{G3}}) begin
      n_err++;
      $display("FAIL clear_setup: hex=%h want %h", hex, {CH{G3}});
    end
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      step((i < 8) ? 4'b0110 : 4'b1111, 2'b10);
      n_vec++;
      if ({hex, press_pulse} !== {exp_hex(), m_pulse}) begin
        n_err++;
        $display("FAIL clear_press[%0d]: hex=%h pulse=%b want hex=%h pulse=%b", i, hex, press_pulse, exp_hex(), m_pulse);
      end
      seen = seen | press_pulse;
    end
    n_vec++;
    if (seen !== 4'b1001 || hex !== {CH{G0}}) begin
      n_err++;
      $display("FAIL clear_priority: pulses %b hex=%h want 1001 and %h", seen, hex, {CH{G0}});
    end
    for (int i = 0; i < 16; i++) step((i < 8) ? 4'b0111 : 4'b1111, 2'b00);
    n_vec++;
    if (hex !== {G1, G0, G0, G0}) begin
      n_err++;
      $display("FAIL clear_then_key3: hex=%h want %h", hex, {G1, G0, G0, G0});
    end
  endtask

  task automatic test_reset_mid_debounce();
    int pe;
    pe = -1;
    do_reset();
    for (int i = 0; i < 3; i++) step('1, 2'b00);
    for (int i = 0; i < 2; i++) step(4'b1110, 2'b00);
    do_reset();
    n_vec++;
    if ({hex, press_pulse} !== {{CH{G0}}, 4'b0000}) begin
      n_err++;
      $display("FAIL midreset_values: hex=%h pulse=%b want %h 0000", hex, press_pulse, {CH{G0}});
    end
    for (int i = 0; i < 12; i++) begin
      step(4'b1110, 2'b00);
      n_vec++;
      if ({hex, press_pulse} !== {exp_hex(), m_pulse}) begin
        n_err++;
        $display("FAIL midreset[%0d]: hex=%h pulse=%b want hex=%h pulse=%b", i, hex, press_pulse, exp_hex(), m_pulse);
      end
      if (press_pulse[0] && pe < 0) pe = i;
    end
    n_vec++;
    if (pe != int'(D) + 1 || hex[6:0] !== G1) begin
      n_err++;
      $display("FAIL midreset_latency: edge %0d digit0 %b want edge %0d and %b", pe, hex[6:0], D + 1, G1);
    end
    for (int i = 0; i < 10; i++) step('1, 2'b00);
  endtask

  task automatic test_random();
    logic [CH-1:0] k;
    logic [1:0]    s;
    k = '1; s = 2'b00;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < int'(CH); c++)
        if ($urandom_range(0, 7) == 0) k[c] = ~k[c];
      if ($urandom_range(0, 19) == 0) s[0] = ~s[0];
      s[1] = ($urandom_range(0, 49) == 0);
      step(k, s);
      n_vec++;
      if ({hex, press_pulse} !== {exp_hex(), m_pulse}) begin
        n_err++;
        $display("FAIL random[%0d]: hex=%h pulse=%b want hex=%h pulse=%b", i, hex, press_pulse, exp_hex(), m_pulse);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap_dir();
    test_clear_concurrency();
    test_reset_mid_debounce();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
